// File: rtl/screen_frame_writer.sv
// 32x32 display writer: pixel commands edit a back buffer; PUSH copies it row-by-row into the front buffer (H cycles), optionally after a vblank rising edge.
// LOAD answers one cycle after acceptance; O_cmd_ready is low for the whole of WAIT_VB, COPY and CLR, so the source must hold its command.
module screen_frame_writer #(
    parameter int W         = 32,
    parameter int H         = 32,
    parameter bit SYNC_PUSH = 1'b1
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_cmd_valid,
    output logic             O_cmd_ready,
    input  logic [2:0]       I_cmd_op,
    input  logic [4:0]       I_cmd_data,
    input  logic             I_vblank,
    output logic             O_load_valid,
    output logic             O_load_data,
    output logic             O_busy,
    output logic [W*H-1:0]   O_front
);
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    localparam logic [2:0] OP_SET_X    = 3'd0;
    localparam logic [2:0] OP_SET_Y    = 3'd1;
    localparam logic [2:0] OP_DRAW     = 3'd2;
    localparam logic [2:0] OP_CLEAR    = 3'd3;
    localparam logic [2:0] OP_LOAD     = 3'd4;
    localparam logic [2:0] OP_PUSH     = 3'd5;
    localparam logic [2:0] OP_CLR_BACK = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VB,
        S_COPY,
        S_CLR
    } state_t;

    state_t                 state;
    logic [CW-1:0]          x;
    logic [RW-1:0]          y;
    logic [RW-1:0]          row;
    logic                   vb_q;
    logic [W-1:0]           back [H];
    logic [H-1:0][W-1:0]    front_q;
    logic [CW-1:0]          bit_idx;
    logic                   last_row;

    // Pixel x lives at bit (W-1-x) so that x=0 is the row's MSB.
    assign bit_idx  = CW'(W - 1) - x;
    assign last_row = (row == RW'(H - 1));
    assign O_front  = front_q;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state        <= S_IDLE;
            x            <= '0;
            y            <= '0;
            row          <= '0;
            vb_q         <= 1'b0;
            O_cmd_ready  <= 1'b1;
            O_busy       <= 1'b0;
            O_load_valid <= 1'b0;
            O_load_data  <= 1'b0;
            front_q      <= '0;
            for (int i = 0; i < H; i++) begin
                back[i] <= '0;
            end
        end else begin
            vb_q         <= I_vblank;
            O_load_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_cmd_valid) begin
                        case (I_cmd_op)
                            OP_SET_X: x <= I_cmd_data[CW-1:0];
                            OP_SET_Y: y <= I_cmd_data[RW-1:0];
                            OP_DRAW:  back[y][bit_idx] <= 1'b1;
                            OP_CLEAR: back[y][bit_idx] <= 1'b0;
                            OP_LOAD: begin
                                O_load_valid <= 1'b1;
                                O_load_data  <= back[y][bit_idx];
                            end
                            OP_PUSH: begin
                                state       <= SYNC_PUSH ? S_WAIT_VB : S_COPY;
                                O_cmd_ready <= 1'b0;
                                O_busy      <= 1'b1;
                            end
                            OP_CLR_BACK: begin
                                state       <= S_CLR;
                                O_cmd_ready <= 1'b0;
                                O_busy      <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WAIT_VB: begin
                    // Only a fresh rise counts; a level already high at PUSH time is ignored.
                    if (I_vblank && !vb_q) begin
                        state <= S_COPY;
                    end
                end
                S_COPY: begin
                    front_q[row] <= back[row];
                    if (last_row) begin
                        row         <= '0;
                        state       <= S_IDLE;
                        O_cmd_ready <= 1'b1;
                        O_busy      <= 1'b0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                S_CLR: begin
                    back[row] <= '0;
                    if (last_row) begin
                        row         <= '0;
                        state       <= S_IDLE;
                        O_cmd_ready <= 1'b1;
                        O_busy      <= 1'b0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
